// File: rtl/axi_wr_burst_sched.sv
// Splits (addr, byte-length) write commands into 4 KB-safe AXI4 INCR bursts and tracks B responses.
// Optional AXI_WR_SCHED_STATS_EN adds wrapping burst and error counters.
module axi_wr_burst_sched #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_BURST_BEATS = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_len,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [8:0]            wb_beats,
    output logic                  done,
    output logic                  done_err,
    output logic                  busy
`ifdef AXI_WR_SCHED_STATS_EN
    ,
    output logic [15:0]           stat_bursts,
    output logic [15:0]           stat_errs
`endif
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int SZ  = $clog2(BPB);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(BPB - 1);
    localparam logic [31:0] LEN_MASK = 32'(BPB - 1);

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, awaddr_q;
    logic [31:0]           beats_left_q;
    logic [7:0]            awlen_q;
    logic [8:0]            wb_beats_q;
    logic [3:0]            out_q, out_d;
    logic                  err_q, cmd_ready_q, busy_q, done_q, done_err_q, bready_q;
    logic                  awvalid_q, wbvalid_q, aw_done_q, wb_done_q, launched_q;
    logic [12:0]           to_4k;
    logic [31:0]           lim;
    logic [8:0]            calc_beats;
    logic                  aw_hs, wb_hs, b_hs, aw_fin, wb_fin, reject;
`ifdef AXI_WR_SCHED_STATS_EN
    logic [15:0]           stat_bursts_q, stat_errs_q;
`endif

    always_comb begin
        aw_hs  = awvalid_q & m_axi_awready;
        wb_hs  = wbvalid_q & wb_ready;
        b_hs   = m_axi_bvalid & bready_q;
        aw_fin = aw_done_q | aw_hs;
        wb_fin = wb_done_q | wb_hs;
        reject = ((cmd_addr & ADDR_MASK) != '0) || ((cmd_len & LEN_MASK) != '0) || (cmd_len == '0);
        to_4k  = (13'd4096 - {1'b0, addr_q[11:0]}) >> SZ;
        lim    = beats_left_q;
        if ({19'd0, to_4k} < lim) lim = {19'd0, to_4k};
        if (32'(MAX_BURST_BEATS) < lim) lim = 32'(MAX_BURST_BEATS);
        calc_beats = 9'(lim);
        // Simultaneous AW and B handshakes cancel out
        case ({aw_hs, b_hs})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            awaddr_q     <= '0;
            beats_left_q <= '0;
            awlen_q      <= '0;
            wb_beats_q   <= '0;
            out_q        <= '0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
            bready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wbvalid_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            wb_done_q    <= 1'b0;
            launched_q   <= 1'b0;
`ifdef AXI_WR_SCHED_STATS_EN
            stat_bursts_q <= '0;
            stat_errs_q   <= '0;
`endif
        end else begin
            out_q      <= out_d;
            bready_q   <= (out_d != '0);
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            if (b_hs && m_axi_bresp != 2'b00) err_q <= 1'b1;
`ifdef AXI_WR_SCHED_STATS_EN
            if (aw_hs) stat_bursts_q <= stat_bursts_q + 16'd1;
            if (b_hs && m_axi_bresp != 2'b00) stat_errs_q <= stat_errs_q + 16'd1;
`endif
            case (state_q)
                IDLE: if (cmd_valid) begin
                    addr_q       <= cmd_addr;
                    beats_left_q <= cmd_len >> SZ;
                    err_q        <= 1'b0;
                    cmd_ready_q  <= 1'b0;
                    busy_q       <= 1'b1;
                    if (reject) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        done_err_q <= 1'b1;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    awaddr_q   <= addr_q;
                    awlen_q    <= 8'(calc_beats - 9'd1);
                    wb_beats_q <= calc_beats;
                    aw_done_q  <= 1'b0;
                    wb_done_q  <= 1'b0;
                    state_q    <= ISSUE;
                    launched_q <= (out_q < MAX_OUT);
                    awvalid_q  <= (out_q < MAX_OUT);
                    wbvalid_q  <= (out_q < MAX_OUT);
                end
                ISSUE: if (!launched_q) begin
                    // Blocked on outstanding cap; the counter is registered so a B frees a slot one cycle later
                    if (out_q < MAX_OUT) begin
                        launched_q <= 1'b1;
                        awvalid_q  <= 1'b1;
                        wbvalid_q  <= 1'b1;
                    end
                end else begin
                    if (aw_hs) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
                    if (wb_hs) begin wbvalid_q <= 1'b0; wb_done_q <= 1'b1; end
                    if (aw_fin && wb_fin) begin
                        addr_q       <= addr_q + (ADDR_WIDTH'(wb_beats_q) << SZ);
                        beats_left_q <= beats_left_q - 32'(wb_beats_q);
                        launched_q   <= 1'b0;
                        state_q      <= (beats_left_q == 32'(wb_beats_q)) ? DRAIN : CALC;
                    end
                end
                DRAIN: if (out_q == '0) begin
                    state_q    <= DONE;
                    done_q     <= 1'b1;
                    done_err_q <= err_q;
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign done_err      = done_err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'(SZ);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_bready  = bready_q;
    assign wb_valid      = wbvalid_q;
    assign wb_beats      = wb_beats_q;
`ifdef AXI_WR_SCHED_STATS_EN
    assign stat_bursts   = stat_bursts_q;
    assign stat_errs     = stat_errs_q;
`endif
endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Randomized bench for axi_wr_burst_sched against a byte-level burst-splitting model.
module tb_axi_wr_burst_sched;
    localparam int MAXO = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_addr = '0, cmd_len = '0;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        awvalid, awready, bvalid, bready, wb_valid, wb_ready, done, done_err, busy;
    logic [8:0]  wb_beats;
`ifdef AXI_WR_SCHED_STATS_EN
    logic [15:0] stat_bursts, stat_errs;
`endif

    axi_wr_burst_sched dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_beats(wb_beats),
        .done(done), .done_err(done_err), .busy(busy)
`ifdef AXI_WR_SCHED_STATS_EN
        , .stat_bursts(stat_bursts), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected bursts and observed handshakes for the current command
    logic [31:0] exp_addr[$], log_addr[$];
    logic [7:0]  exp_len[$], log_len[$];
    logic [8:0]  exp_beats[$], log_beats[$];
    int  mdl_out = 0, aw_total = 0, b_presented = 0, b_cmd_idx = 0, b_total = 0;
    bit  mdl_err = 0, active = 0, done_seen = 0, acc_flag = 0, b_hs_flag = 0, last_done_err = 0;
    bit  b_en = 1, b_single = 0;
    int  b_pct = 100, aw_pct = 100, wb_pct = 100, err_mode = 0, err_idx = 0;
    int  acc_cyc = 0, done_cyc = 0, first_aw = -1, aw_rise_cyc = -1, aw_vld_cnt = 0, b_hs_cyc = -1;
    logic        p_awv = 0, p_awr = 0, p_wbv = 0, p_wbr = 0;
    logic [31:0] p_awaddr = 0;
    logic [7:0]  p_awlen = 0;
    logic [8:0]  p_beats = 0;

    always @(negedge clk) begin
        if (rst) begin
            p_awv = 0; p_wbv = 0;
        end else begin
            chk("awsize", awsize, 3'd2);
            chk("awburst", awburst, 2'b01);
            chk("bready", bready, mdl_out != 0);
            chk("busy", busy, active);
            chk("cmd_ready", cmd_ready, !active);
            if (p_awv && !p_awr) begin
                chk("aw_hold", awvalid, 1'b1);
                chk("aw_addr_hold", awaddr, p_awaddr);
                chk("aw_len_hold", awlen, p_awlen);
            end
            if (p_wbv && !p_wbr) begin
                chk("wb_hold", wb_valid, 1'b1);
                chk("wb_beats_hold", wb_beats, p_beats);
            end
            if (awvalid) aw_vld_cnt++;
            if (awvalid && first_aw < 0) first_aw = cyc;
            if (awvalid && !p_awv) aw_rise_cyc = cyc;
            b_hs_flag = bvalid && bready;
            if (awvalid && awready) begin
                chk("aw_cap", mdl_out < MAXO, 1'b1);
                chk("aw_expected", exp_addr.size() != 0, 1'b1);
                if (exp_addr.size() != 0) begin
                    chk("awaddr", awaddr, exp_addr.pop_front());
                    chk("awlen", awlen, exp_len.pop_front());
                end
                log_addr.push_back(awaddr);
                log_len.push_back(awlen);
                mdl_out++;
                aw_total++;
            end
            if (wb_valid && wb_ready) begin
                chk("wb_expected", exp_beats.size() != 0, 1'b1);
                if (exp_beats.size() != 0) chk("wb_beats", wb_beats, exp_beats.pop_front());
                log_beats.push_back(wb_beats);
            end
            if (b_hs_flag) begin
                mdl_out--;
                b_total++;
                b_hs_cyc = cyc;
                if (bresp != 2'b00) mdl_err = 1;
            end
            if (done) begin
                chk("done_err", done_err, mdl_err);
                chk("done_aw_left", exp_addr.size(), 0);
                chk("done_wb_left", exp_beats.size(), 0);
                chk("done_outstanding", mdl_out, 0);
                done_seen = 1; done_cyc = cyc; last_done_err = done_err; active = 0;
            end
            if (cmd_valid && cmd_ready) begin
                acc_flag = 1; acc_cyc = cyc; active = 1;
            end
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr; p_awlen = awlen;
            p_wbv = wb_valid; p_wbr = wb_ready; p_beats = wb_beats;
        end
    end

    initial begin
        bvalid = 0; bresp = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bvalid = 0; bresp = 0;
            end else if (!bvalid || b_hs_flag) begin
                bvalid = 0; bresp = 0;
                if (aw_total > b_presented && ((b_en && $urandom_range(99) < b_pct) || b_single)) begin
                    bvalid = 1; b_single = 0;
                    if (err_mode == 1) bresp = (b_cmd_idx == err_idx) ? 2'b10 : 2'b00;
                    else if (err_mode == 2) bresp = ($urandom_range(7) == 0) ? 2'b10 : 2'b00;
                    b_presented++; b_cmd_idx++;
                end
            end
        end
    end

    initial begin
        awready = 0; wb_ready = 0;
        forever begin
            @(posedge clk); #1;
            awready = ($urandom_range(99) < aw_pct);
            wb_ready = ($urandom_range(99) < wb_pct);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        exp_addr.delete(); exp_len.delete(); exp_beats.delete();
        mdl_out = 0; aw_total = 0; b_presented = 0; active = 0; b_hs_flag = 0;
    endtask

    task automatic do_reset();
        rst = 1; cmd_valid = 0;
        clear_model();
        repeat (3) tick();
        rst = 0;
        tick();
    endtask

    // Byte-granular splitting: each burst takes the smallest of bytes left, bytes to the 4 KB page end, 64 bytes
    task automatic start_cmd(input logic [31:0] a, input logic [31:0] l);
        longint ad, rem, n, lim;
        int k;
        bit rej;
        rej = (a % 4 != 0) || (l % 4 != 0) || (l == 0);
        log_addr.delete(); log_len.delete(); log_beats.delete();
        if (!rej) begin
            ad = a; rem = l;
            while (rem > 0) begin
                n = rem;
                lim = 4096 - (ad % 4096);
                if (lim < n) n = lim;
                if (64 < n) n = 64;
                exp_addr.push_back(ad[31:0]);
                exp_len.push_back(8'(n / 4 - 1));
                exp_beats.push_back(9'(n / 4));
                ad += n; rem -= n;
            end
        end
        mdl_err = rej; done_seen = 0; acc_flag = 0; first_aw = -1; b_cmd_idx = 0;
        cmd_valid = 1; cmd_addr = a; cmd_len = l;
        k = 0;
        while (!acc_flag && k < 100) begin tick(); k++; end
        chk("cmd_accept_timeout", acc_flag, 1'b1);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done_seen && k < budget) begin tick(); k++; end
        chk("done_timeout", done_seen, 1'b1);
        tick();
    endtask

    initial begin
        int k, nb, vc;
        logic [31:0] a, l;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_done", {done, done_err, busy}, 3'b000);
        chk("rst_awsize", awsize, 3'd2);
        chk("rst_awburst", awburst, 2'b01);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_awlen_beats", {awlen, wb_beats}, 17'h0);
        rst = 0;
        tick();

        start_cmd(32'h1000, 64);
        wait_done(200);
        chk("s1_first_aw_latency", first_aw - acc_cyc, 2);
        chk("s1_count", log_addr.size(), 1);
        chk("s1_addr", log_addr[0], 32'h1000);
        chk("s1_len", log_len[0], 8'd15);
        chk("s1_beats", log_beats[0], 9'd16);
        chk("s1_err", last_done_err, 1'b0);

        start_cmd(32'h0FF0, 32);
        wait_done(200);
        chk("s2_count", log_addr.size(), 2);
        chk("s2_addr0", log_addr[0], 32'h0FF0);
        chk("s2_len0", log_len[0], 8'd3);
        chk("s2_addr1", log_addr[1], 32'h1000);
        chk("s2_len1", log_len[1], 8'd3);

        start_cmd(32'h2000, 256);
        wait_done(300);
        chk("s3_count", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk("s3_addr", log_addr[i], 32'h2000 + 32'(i * 64));
            chk("s3_len", log_len[i], 8'd15);
        end

        vc = aw_vld_cnt;
        start_cmd(32'h3002, 16);
        wait_done(20);
        chk("rej_done_latency", done_cyc - acc_cyc, 1);
        chk("rej_err", last_done_err, 1'b1);
        chk("rej_no_awvalid", aw_vld_cnt, vc);
        start_cmd(32'h3000, 0);
        wait_done(20);
        chk("rej_len0_err", last_done_err, 1'b1);
        start_cmd(32'h3000, 18);
        wait_done(20);
        chk("rej_len_mod_err", last_done_err, 1'b1);

        b_en = 0;
        start_cmd(32'h4000, 512);
        repeat (40) tick();
        chk("hold_aw_count", log_addr.size(), MAXO);
        chk("hold_awvalid_low", awvalid, 1'b0);
        nb = b_total;
        b_single = 1;
        k = 0;
        while (b_total == nb && k < 20) begin tick(); k++; end
        k = 0;
        while (aw_rise_cyc <= b_hs_cyc && k < 20) begin tick(); k++; end
        chk("hold_unblock_gap", aw_rise_cyc - b_hs_cyc, 2);
        b_en = 1;
        wait_done(500);
        chk("hold_count", log_addr.size(), 8);
        chk("hold_last_addr", log_addr[log_addr.size() - 1], 32'h41C0);

        do_reset();
        aw_pct = 70; wb_pct = 70; b_pct = 60; err_mode = 1; err_idx = 1;
        start_cmd(32'h4000, 512);
        wait_done(1000);
        chk("err_count", log_addr.size(), 8);
        chk("err_done_err", last_done_err, 1'b1);
`ifdef AXI_WR_SCHED_STATS_EN
        chk("stat_errs", stat_errs, 16'd1);
        chk("stat_bursts", stat_bursts, 16'd8);
`endif

        err_mode = 0; aw_pct = 100; wb_pct = 100; b_pct = 100;
        start_cmd(32'h5000, 1024);
        repeat (10) tick();
        rst = 1;
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_valids", {awvalid, wb_valid}, 2'b00);
        chk("midrst_bready", bready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        do_reset();
        start_cmd(32'h6000, 128);
        wait_done(300);
        chk("post_rst_count", log_addr.size(), 2);
        chk("post_rst_addr1", log_addr[1], 32'h6040);

        err_mode = 2;
        for (int i = 0; i < 25; i++) begin
            aw_pct = $urandom_range(30, 100);
            wb_pct = $urandom_range(30, 100);
            b_pct  = $urandom_range(20, 100);
            a = 32'($urandom_range(1, 15) * 4096) - 32'($urandom_range(0, 40) * 4);
            l = 32'($urandom_range(1, 80) * 4);
            if ($urandom_range(7) == 0) a = a + 2;
            if ($urandom_range(15) == 0) l = l + 1;
            if ($urandom_range(15) == 0) l = 0;
            start_cmd(a, l);
            wait_done(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
